send_capture_framed: RTL and testbench

//  Parametrised successor to the capture-dump sender. Reads a run-time selected window of capture

---
 rtl/send_capture_framed.sv | 145 ++++++++++++++
 tb/tb_send_capture_framed.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/send_capture_framed.sv
// Capture-dump sender: reads a descending, wrapping window of capture RAM and streams it to the
// UART octet by octet, framed by a sync header and an optional 8-bit additive checksum trailer.
module send_capture_framed #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WORD_OCTETS = 4,
  parameter bit          MSB_FIRST   = 1'b0,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter bit          SEND_CSUM   = 1'b1,
  localparam int unsigned W          = 8 * WORD_OCTETS
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 baud_clk_posedge,
  input  logic                 sc_run,
  input  logic                 sc_abort,
  input  logic [ADDR_BITS-1:0] sc_start_addr,
  input  logic [ADDR_BITS:0]   sc_word_count,
  output logic                 ack_sc_run,
  output logic                 sc_busy,
  output logic                 sc_done,
  output logic [ADDR_BITS-1:0] mem_port_B_address,
  input  logic [W-1:0]         mem_port_B_dout,
  input  logic                 xmit_doneH,
  output logic                 xmitH,
  output logic [7:0]           xmit_dataH
);

  localparam int unsigned IDX_W = $clog2(WORD_OCTETS + 1);
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ACK       = 4'd1;
  localparam logic [3:0] S_HDR       = 4'd2;
  localparam logic [3:0] S_HDR_WAIT  = 4'd3;
  localparam logic [3:0] S_SET_ADDR  = 4'd4;
  localparam logic [3:0] S_GET_DATA  = 4'd5;
  localparam logic [3:0] S_SEND      = 4'd6;
  localparam logic [3:0] S_WAIT      = 4'd7;
  localparam logic [3:0] S_WORD_SENT = 4'd8;
  localparam logic [3:0] S_TRAILER   = 4'd9;
  localparam logic [3:0] S_TR_WAIT   = 4'd10;
  localparam logic [3:0] S_DONE      = 4'd11;

  logic [3:0]           r_state;
  logic [3:0]           w_state_nxt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic [W-1:0]         r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_csum;
  logic                 w_abort;
  logic [7:0]           w_octet;

  assign w_abort            = sc_abort && (r_state != S_IDLE);
  assign w_octet            = MSB_FIRST ? r_shift[W-1 -: 8] : r_shift[7:0];
  assign mem_port_B_address = r_addr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                r_state <= S_IDLE;
    else if (baud_clk_posedge) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (sc_run) w_state_nxt = S_ACK;
        S_ACK:       w_state_nxt = S_HDR;
        S_HDR:       w_state_nxt = S_HDR_WAIT;
        S_HDR_WAIT:  if (xmit_doneH) w_state_nxt = (r_cnt == '0) ? S_TRAILER : S_SET_ADDR;
        S_SET_ADDR:  w_state_nxt = S_GET_DATA;
        S_GET_DATA:  w_state_nxt = S_SEND;
        S_SEND:      w_state_nxt = S_WAIT;
        S_WAIT:      if (xmit_doneH)
                       w_state_nxt = (r_idx < IDX_W'(WORD_OCTETS)) ? S_SEND : S_WORD_SENT;
        S_WORD_SENT: w_state_nxt = (r_cnt != CNT_W'(1)) ? S_SET_ADDR : S_TRAILER;
        S_TRAILER:   w_state_nxt = SEND_CSUM ? S_TR_WAIT : S_DONE;
        S_TR_WAIT:   if (xmit_doneH) w_state_nxt = S_DONE;
        S_DONE:      w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode the current state only, so they hold for the whole enabled interval.
  always_comb begin
    ack_sc_run = 1'b0;
    sc_busy    = 1'b1;
    sc_done    = 1'b0;
    xmitH      = 1'b0;
    xmit_dataH = 8'h00;
    case (r_state)
      S_IDLE:    sc_busy = 1'b0;
      S_ACK:     ack_sc_run = 1'b1;
      S_HDR:     begin xmitH = 1'b1; xmit_dataH = SYNC_BYTE; end
      S_SEND:    begin xmitH = 1'b1; xmit_dataH = w_octet; end
      S_TRAILER: if (SEND_CSUM) begin xmitH = 1'b1; xmit_dataH = r_csum; end
      S_DONE:    sc_done = 1'b1;
      S_HDR_WAIT, S_SET_ADDR, S_GET_DATA, S_WAIT, S_WORD_SENT, S_TR_WAIT: ;
      default: begin
        ack_sc_run = 1'bx;
        sc_busy    = 1'bx;
        sc_done    = 1'bx;
        xmitH      = 1'bx;
        xmit_dataH = 8'hxx;
      end
    endcase
  end

  // Window address/count, word shifter and running checksum.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
    end else if (baud_clk_posedge && !w_abort) begin
      case (r_state)
        S_IDLE: if (sc_run) begin
          r_addr <= sc_start_addr;
          r_cnt  <= sc_word_count;
          r_csum <= 8'h00;
        end
        S_GET_DATA: begin
          r_shift <= mem_port_B_dout;
          r_idx   <= '0;
        end
        S_SEND: begin
          r_shift <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
          r_csum  <= r_csum + w_octet;
          r_idx   <= r_idx + IDX_W'(1);
        end
        S_WORD_SENT: begin
          r_cnt  <= r_cnt - CNT_W'(1);
          r_addr <= r_addr - ADDR_BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_send_capture_framed.sv
// Bench for send_capture_framed: LSB-first and MSB-first instances share stimulus; each UART
// model records octets, which are compared with frames built from the RAM contents.
module tb_send_capture_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l = 1'b0;
  logic        baud = 1'b1;
  logic        slow = 1'b0;
  logic [3:0]  div = 4'd0;
  logic        sc_run = 1'b0;
  logic        sc_abort = 1'b0;
  logic [3:0]  sc_start_addr = 4'd0;
  logic [4:0]  sc_word_count = 5'd0;
  logic [1:0]  ack_w, busy_w, sdone_w, xm_w;
  logic [1:0]  dh = 2'b00;
  logic [7:0]  xd_w [2];
  logic [3:0]  addr_w [2];
  logic [31:0] dout_r [2];
  logic [31:0] ram [16];

  int errors = 0;
  int checks = 0;
  int ack_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int ucnt [2] = '{0, 0};
  bit ubusy [2] = '{1'b0, 1'b0};
  int viol = 0;
  int unsigned rnd;
  logic [15:0] vcur, vprev = '0;
  logic pbaud = 1'b1, prst = 1'b0;
  logic [7:0] cap0 [$], cap1 [$], e0 [$], e1 [$];
  int a0, d0, d1;
  bit ok;

  send_capture_framed #(.ADDR_BITS(4), .WORD_OCTETS(4), .MSB_FIRST(1'b0),
                        .SYNC_BYTE(8'hA5), .SEND_CSUM(1'b1)) u_lsb (
    .clk(clk), .rst_l(rst_l), .baud_clk_posedge(baud), .sc_run(sc_run), .sc_abort(sc_abort),
    .sc_start_addr(sc_start_addr), .sc_word_count(sc_word_count), .ack_sc_run(ack_w[0]),
    .sc_busy(busy_w[0]), .sc_done(sdone_w[0]), .mem_port_B_address(addr_w[0]),
    .mem_port_B_dout(dout_r[0]), .xmit_doneH(dh[0]), .xmitH(xm_w[0]), .xmit_dataH(xd_w[0]));

  send_capture_framed #(.ADDR_BITS(4), .WORD_OCTETS(4), .MSB_FIRST(1'b1),
                        .SYNC_BYTE(8'hA5), .SEND_CSUM(1'b1)) u_msb (
    .clk(clk), .rst_l(rst_l), .baud_clk_posedge(baud), .sc_run(sc_run), .sc_abort(sc_abort),
    .sc_start_addr(sc_start_addr), .sc_word_count(sc_word_count), .ack_sc_run(ack_w[1]),
    .sc_busy(busy_w[1]), .sc_done(sdone_w[1]), .mem_port_B_address(addr_w[1]),
    .mem_port_B_dout(dout_r[1]), .xmit_doneH(dh[1]), .xmit_dataH(xd_w[1]), .xmitH(xm_w[1]));

  // Baud enable: every clock, or one clock in sixteen.
  always @(posedge clk) begin
    div  <= div + 4'd1;
    baud <= slow ? (div == 4'd14) : 1'b1;
  end

  // Capture RAM with one-cycle read latency.
  always @(posedge clk) begin
    dout_r[0] <= ram[addr_w[0]];
    dout_r[1] <= ram[addr_w[1]];
  end

  // UART models and pulse counters; baud seen here applies to the next rising edge.
  always @(negedge clk) begin
    rnd = $urandom_range(0, 4);
    for (int k = 0; k < 2; k++) begin
      if (!rst_l) begin
        dh[k]    = 1'b0;
        ubusy[k] = 1'b0;
      end else begin
        if (baud && ack_w[k])   ack_cnt[k]++;
        if (baud && sdone_w[k]) done_cnt[k]++;
        if (baud && xm_w[k]) begin
          if (k == 0) cap0.push_back(xd_w[k]);
          else        cap1.push_back(xd_w[k]);
          dh[k]    = 1'b0;
          ucnt[k]  = int'(rnd);
          ubusy[k] = 1'b1;
        end else if (ubusy[k]) begin
          if (ucnt[k] == 0) begin
            dh[k]    = 1'b1;
            ubusy[k] = 1'b0;
          end else begin
            ucnt[k]--;
          end
        end
      end
    end
    vcur = {ack_w[0], busy_w[0], sdone_w[0], xm_w[0], xd_w[0], addr_w[0]};
    if (rst_l && prst && !pbaud && (vcur !== vprev)) viol++;
    vprev = vcur;
    pbaud = baud;
    prst  = rst_l;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input int start, input int count);
    int s0, s1, a;
    logic [31:0] word;
    e0.delete(); e1.delete();
    e0.push_back(8'hA5); e1.push_back(8'hA5);
    s0 = 0; s1 = 0;
    for (int w = 0; w < count; w++) begin
      a = (((start - w) % 16) + 16) % 16;
      word = ram[a];
      for (int o = 0; o < 4; o++) begin
        e0.push_back(word[8*o +: 8]);
        e1.push_back(word[8*(3-o) +: 8]);
        s0 += int'(word[8*o +: 8]);
        s1 += int'(word[8*(3-o) +: 8]);
      end
    end
    e0.push_back(8'(s0 % 256));
    e1.push_back(8'(s1 % 256));
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_l = 1'b0; sc_run = 1'b0; sc_abort = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_l = 1'b1;
  endtask

  task automatic start_dump(input int start, input int count);
    a0 = ack_cnt[0];
    @(negedge clk); #1;
    sc_start_addr = 4'(start);
    sc_word_count = 5'(count);
    sc_run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (ack_cnt[0] != a0);
    end
    sc_run = 1'b0;
  endtask

  task automatic run_dump(input int start, input int count, input string tag);
    build_exp(start, count);
    cap0.delete(); cap1.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    start_dump(start, count);
    for (int i = 0; i < 40000 && !((done_cnt[0] != d0) && (done_cnt[1] != d1)); i++) begin
      @(negedge clk); #1;
    end
    ok = (done_cnt[0] != d0) && (done_cnt[1] != d1);
    chk({tag, " done"}, 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    #1;
    chk({tag, " lsb len"}, 32'(cap0.size()), 32'(e0.size()));
    chk({tag, " msb len"}, 32'(cap1.size()), 32'(e1.size()));
    for (int i = 0; i < e0.size() && i < cap0.size(); i++)
      chk($sformatf("%s lsb oct%0d", tag, i), 32'(cap0[i]), 32'(e0[i]));
    for (int i = 0; i < e1.size() && i < cap1.size(); i++)
      chk($sformatf("%s msb oct%0d", tag, i), 32'(cap1[i]), 32'(e1[i]));
    chk({tag, " done pulses"}, 32'(done_cnt[0] - d0), 32'd1);
    chk({tag, " ack pulses"}, 32'(ack_cnt[0] - a0), 32'd1);
    chk({tag, " idle"}, 32'(busy_w), 32'd0);
    if (!ok) do_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'(32'h0403_0201 * (i + 1));
    repeat (3) @(negedge clk);
    #1;
    chk("reset lsb", 32'({ack_w[0], busy_w[0], sdone_w[0], xm_w[0], xd_w[0], addr_w[0]}), 32'd0);
    chk("reset msb", 32'({ack_w[1], busy_w[1], sdone_w[1], xm_w[1], xd_w[1], addr_w[1]}), 32'd0);
    rst_l = 1'b1;

    run_dump(3, 4, "basic");
    run_dump(1, 3, "wrap");
    run_dump(0, 0, "empty");
    run_dump(7, 16, "full");

    // Abort while waiting on the first octet of the second word.
    cap0.delete();
    d0 = done_cnt[0];
    start_dump(5, 3);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (cap0.size() >= 6);
    end
    @(negedge clk); #1;
    sc_abort = 1'b1;
    for (int i = 0; i < 100 && !baud; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    sc_abort = 1'b0;
    chk("abort busy", 32'(busy_w), 32'd0);
    chk("abort octets", 32'(cap0.size()), 32'd6);
    repeat (50) @(negedge clk);
    #1;
    chk("abort no done", 32'(done_cnt[0] - d0), 32'd0);
    chk("abort stays idle", 32'(busy_w), 32'd0);

    // Asynchronous reset in the middle of a dump.
    cap0.delete();
    start_dump(2, 4);
    for (int i = 0; i < 2000 && cap0.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    rst_l = 1'b0;
    #1;
    chk("midreset lsb", 32'({ack_w[0], busy_w[0], sdone_w[0], xm_w[0], xd_w[0], addr_w[0]}), 32'd0);
    chk("midreset msb", 32'({ack_w[1], busy_w[1], sdone_w[1], xm_w[1], xd_w[1], addr_w[1]}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_l = 1'b1;

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) ram[i] = $urandom;
      run_dump(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), $sformatf("rand%0d", r));
    end

    slow = 1'b1;
    run_dump(9, 2, "slow");
    run_dump(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "slow rand");
    slow = 1'b0;
    chk("gated edges", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
